lpc_packer: RTL and testbench
=============================

LPC_PACKER -- requirements
Module: lpc_packer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, record FIFO depth (power of two, >=2).
REQ-002 SHALL have port lpc_clock  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port lpc_reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_cyctype_dir  input  4  decoded cycle type/direction from LPC decoder.
REQ-005 SHALL have port in_addr  input  32  decoded address.
REQ-006 SHALL have port in_data  input  32  decoded data, byte 0 in [7:0].
REQ-007 SHALL have port in_data_size  input  4  data byte count.
REQ-008 SHALL have port in_valid  input  1  one-cycle strobe; record fields valid (decoder out_clock_enable).
REQ-009 SHALL have port out_byte  output  8  serialized packet byte.
REQ-010 SHALL have port out_valid  output  1  out_byte valid.
REQ-011 SHALL have port out_ready  input  1  sink accepts byte when high with out_valid.
REQ-012 SHALL have port overflow  output  1  sticky; set on any dropped record.
REQ-013 SHALL have port drop_count  output  8  saturating count of dropped records.

Function
REQ-014 SHALL, on an lpc_clock edge with in_valid high, write {cyctype_dir, addr, data, size} into the FIFO if not full, or if full and a pop occurs on the same edge.
REQ-015 SHALL, on in_valid while full with no same-edge pop, discard the record, set overflow, and increment drop_count, saturating at 0xFF.
REQ-016 SHALL serialize with FSM states IDLE, SYNC, TYPE, ADDR, DATA, CSUM.
REQ-017 SHALL pop the FIFO head in IDLE when not empty and enter SYNC on the next edge.
REQ-018 SHALL keep out_valid high in every non-IDLE state, and low in IDLE.
REQ-019 SHALL emit packet bytes as follows: SYNC 0xA5; TYPE {cyctype_dir, size_eff[3:0]}; ADDR 4 bytes with addr[31:24] first; DATA size_eff bytes with data[7:0] first.
REQ-020 SHALL compute size_eff as 0 when in_data_size==0, in_data_size when it is 1..4, and 4 when >4; size_eff==0 skips DATA.
REQ-021 SHALL advance a byte or state only on an edge where out_valid && out_ready; out_byte SHALL hold stable while out_ready is low.
REQ-022 SHALL, after the last byte is accepted, go to IDLE, or go directly to SYNC with a same-edge pop when the FIFO is non-empty (no idle bubble).
REQ-023 SHALL have latency: in_valid at edge N into an empty FIFO and idle FSM gives out_valid high with 0xA5 after edge N+2.
REQ-024 SHALL not clear overflow or drop_count except by reset.

Reset
REQ-025 SHALL, on assertion of lpc_reset low, immediately empty the FIFO, set the FSM to IDLE, and drive out_valid=0, out_byte=0x00, overflow=0, drop_count=0.
REQ-026 SHALL, on reset mid-packet, abandon the packet and not resume it after release.

Configuration
REQ-027 SHALL, with LPC_PACKER_CHECKSUM_EN defined, enter CSUM after DATA (or after ADDR when size_eff==0) and emit the XOR of all preceding packet bytes, SYNC included.
REQ-028 SHALL, without LPC_PACKER_CHECKSUM_EN, have no CSUM state or logic, and the packet SHALL end at the last DATA or ADDR byte.

Structure
REQ-029 SHALL take the FSM state encoding, SYNC_BYTE=0xA5, and the record width (72 bits) from shared package lpc_pkg.
REQ-030 SHALL implement the FIFO as sub-module lpc_record_fifo (parameter DEPTH, push/pop/full/empty); the serializer FSM SHALL live in lpc_packer.

Verification
REQ-031 SHALL verify: single I/O read ct_dir=0, addr=0x7fe5, data=0x6c, size=1, out_ready=1 -> A5 01 00 00 7F E5 6C, plus 52 with LPC_PACKER_CHECKSUM_EN.
REQ-032 SHALL verify: size=4, data=0x11223344, addr=0x0 -> DATA bytes 44 33 22 11; size=9 -> same 4 bytes, TYPE low nibble 4.
REQ-033 SHALL verify: out_ready low for 5 cycles mid-ADDR -> out_byte held, no byte lost or duplicated.
REQ-034 SHALL verify: out_ready=0 with DEPTH+3 strobes -> DEPTH packets later emitted in order, overflow=1, drop_count=3.
REQ-035 SHALL verify: back-to-back records with out_ready=1 -> second SYNC directly follows the first packet's last byte, with no idle cycle.
REQ-036 SHALL verify: reset asserted mid-DATA -> out_valid=0 asynchronously and no output after release until a new in_valid.

Source files
------------

// File: rtl/lpc_pkg.sv
// Shared record layout, sync byte and serializer state encoding for the LPC packer.
// LPC_PACKER_CHECKSUM_EN adds the trailing XOR checksum state.
package lpc_pkg;

    localparam int unsigned REC_W     = 72;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_TYPE,
        ST_ADDR,
        ST_DATA
`ifdef LPC_PACKER_CHECKSUM_EN
        , ST_CSUM
`endif
    } pkt_state_e;

    typedef struct packed {
        logic [3:0]  cyctype_dir;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  size;
    } lpc_rec_t;

    // Oversized transfers are clamped to a full 32-bit word.
    function automatic logic [3:0] eff_size(input logic [3:0] s);
        if (s > 4'd4) return 4'd4;
        return s;
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
        return 8'(w >> {k, 3'b000});
    endfunction

endpackage

// File: rtl/lpc_record_fifo.sv
// Power-of-two record FIFO with combinational head read; push while full is legal
// only when a pop happens on the same edge.
module lpc_record_fifo
    import lpc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [REC_W-1:0] wdata_i,
    input  logic             pop_i,
    output logic [REC_W-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [REC_W-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
            if (pop_i)  rd_ptr_q <= rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/lpc_packer.sv
// Buffers decoded LPC records and serializes each as SYNC/TYPE/ADDR/DATA bytes.
// Define LPC_PACKER_CHECKSUM_EN to append an XOR checksum byte to every packet.
module lpc_packer
    import lpc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        lpc_clock,
    input  logic        lpc_reset,
    input  logic [3:0]  in_cyctype_dir,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_data_size,
    input  logic        in_valid,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
    output logic [7:0]  drop_count
);

    lpc_rec_t   wr_rec, head, rec_q;
    logic       fifo_full, fifo_empty, push, pop, drop;
    logic       accept, body_end, last_byte;
    logic [3:0] size_eff;

    pkt_state_e state_q;
    logic [1:0] idx_q;
    logic       load_q;
    logic [7:0] out_byte_q;
    logic       out_valid_q;
    logic       overflow_q;
    logic [7:0] drop_count_q;
`ifdef LPC_PACKER_CHECKSUM_EN
    logic [7:0] csum_q;
`endif

    assign wr_rec = '{cyctype_dir: in_cyctype_dir, addr: in_addr, data: in_data, size: in_data_size};

    always_comb begin
        accept   = out_valid_q && out_ready;
        size_eff = eff_size(rec_q.size);
        body_end = 1'b0;
        case (state_q)
            ST_ADDR: body_end = (idx_q == 2'd3) && (size_eff == 4'd0);
            ST_DATA: body_end = (({2'b00, idx_q} + 4'd1) == size_eff);
            default: body_end = 1'b0;
        endcase
`ifdef LPC_PACKER_CHECKSUM_EN
        last_byte = (state_q == ST_CSUM);
`else
        last_byte = body_end;
`endif
        // Head is taken either from an idle FSM or on the final byte of a packet.
        pop  = !fifo_empty && (((state_q == ST_IDLE) && !load_q) || (accept && last_byte));
        push = in_valid && (!fifo_full || pop);
        drop = in_valid && fifo_full && !pop;
    end

    lpc_record_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (lpc_clock),
        .rst_ni  (lpc_reset),
        .push_i  (push),
        .wdata_i (wr_rec),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            state_q     <= ST_IDLE;
            rec_q       <= '0;
            idx_q       <= '0;
            load_q      <= 1'b0;
            out_byte_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef LPC_PACKER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            if (pop) rec_q <= head;
            if (state_q == ST_IDLE) begin
                if (load_q) begin
                    load_q      <= 1'b0;
                    state_q     <= ST_SYNC;
                    out_valid_q <= 1'b1;
                    out_byte_q  <= SYNC_BYTE;
`ifdef LPC_PACKER_CHECKSUM_EN
                    csum_q      <= '0;
`endif
                end else if (!fifo_empty) begin
                    load_q <= 1'b1;
                end
            end else if (accept) begin
`ifdef LPC_PACKER_CHECKSUM_EN
                csum_q <= csum_q ^ out_byte_q;
`endif
                if (last_byte) begin
                    if (!fifo_empty) begin
                        state_q    <= ST_SYNC;
                        out_byte_q <= SYNC_BYTE;
`ifdef LPC_PACKER_CHECKSUM_EN
                        csum_q     <= '0;
`endif
                    end else begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        out_byte_q  <= '0;
                    end
                end else begin
                    case (state_q)
                        ST_SYNC: begin
                            state_q    <= ST_TYPE;
                            out_byte_q <= {rec_q.cyctype_dir, size_eff};
                        end
                        ST_TYPE: begin
                            state_q    <= ST_ADDR;
                            idx_q      <= '0;
                            out_byte_q <= byte_of(rec_q.addr, 2'd3);
                        end
                        ST_ADDR: begin
                            if (idx_q != 2'd3) begin
                                idx_q      <= idx_q + 2'd1;
                                out_byte_q <= byte_of(rec_q.addr, 2'd2 - idx_q);
                            end
`ifdef LPC_PACKER_CHECKSUM_EN
                            else if (body_end) begin
                                state_q    <= ST_CSUM;
                                out_byte_q <= csum_q ^ out_byte_q;
                            end
`endif
                            else begin
                                state_q    <= ST_DATA;
                                idx_q      <= '0;
                                out_byte_q <= byte_of(rec_q.data, 2'd0);
                            end
                        end
                        ST_DATA: begin
`ifdef LPC_PACKER_CHECKSUM_EN
                            if (body_end) begin
                                state_q    <= ST_CSUM;
                                out_byte_q <= csum_q ^ out_byte_q;
                            end else
`endif
                            begin
                                idx_q      <= idx_q + 2'd1;
                                out_byte_q <= byte_of(rec_q.data, idx_q + 2'd1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
        end
    end

    assign out_byte   = out_byte_q;
    assign out_valid  = out_valid_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_lpc_packer.sv
// Scoreboard bench for lpc_packer: stimulus queues hand-computed packet bytes,
// a negedge monitor pops and compares every accepted output byte.
module tb_lpc_packer;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ct;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  size;
    logic        in_valid;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic [7:0]  drop_count;

    logic [7:0]  exp_q [$];
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned acc_cnt = 0;

    always #5 clk = ~clk;

    lpc_packer #(.DEPTH(DEPTH)) dut (
        .lpc_clock      (clk),
        .lpc_reset      (rst_n),
        .in_cyctype_dir (ct),
        .in_addr        (addr),
        .in_data        (data),
        .in_data_size   (size),
        .in_valid       (in_valid),
        .out_byte       (out_byte),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_byte actual=%h required=none", out_byte);
            end else begin
                check("out_byte", 32'(out_byte), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // v holds up to ten bytes, first byte in [79:72]; cs is appended only with the checksum build.
    task automatic expect_pkt(input logic [79:0] v, input int unsigned n, input logic [7:0] cs);
        for (int unsigned i = 0; i < n; i++) exp_q.push_back(8'(v >> (72 - 8 * i)));
`ifdef LPC_PACKER_CHECKSUM_EN
        exp_q.push_back(cs);
`else
        if (cs === 8'hxx) exp_q.push_back(cs);
`endif
    endtask

    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        ct = c; addr = a; data = d; size = s;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_acc(input int unsigned target, input string name);
        for (int unsigned i = 0; i < 400 && acc_cnt < target; i++) cyc();
        if (acc_cnt < target) begin
            total++;
            bad++;
            $display("FAIL %s_timeout actual=%0d required=%0d", name, acc_cnt, target);
        end
    endtask

    task automatic drain(input string name);
        wait_acc(acc_cnt + exp_q.size(), name);
    endtask

    initial begin
        int unsigned base;
        int unsigned gaps;
        rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        ct = '0; addr = '0; data = '0; size = '0;
        repeat (3) cyc();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_byte", 32'(out_byte), 32'h00);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        rst_n = 1'b1;
        repeat (2) cyc();

        // Single I/O read with latency check: strobe at edge N, SYNC visible after N+2.
        expect_pkt({56'hA5_01_0000_7FE5_6C, 24'h0}, 7, 8'h52);
        ct = 4'h0; addr = 32'h7fe5; data = 32'h6c; size = 4'd1; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        check("lat_after_n", 32'(out_valid), 32'd0);
        cyc();
        check("lat_after_n1", 32'(out_valid), 32'd0);
        cyc();
        check("lat_valid_n2", 32'(out_valid), 32'd1);
        check("lat_sync_n2", 32'(out_byte), 32'hA5);
        drain("v1");

        expect_pkt(80'hA5_04_0000_0000_4433_2211, 10, 8'hE5);
        send(4'h0, 32'h0, 32'h11223344, 4'd4);
        drain("size4");

        expect_pkt(80'hA5_24_0000_0000_4433_2211, 10, 8'hC5);
        send(4'h2, 32'h0, 32'h11223344, 4'd9);
        drain("size9");

        // Stall mid-ADDR after the first address byte is taken.
        base = acc_cnt;
        expect_pkt({48'hA5_10_1234_5678, 32'h0}, 6, 8'hBD);
        send(4'h1, 32'h12345678, 32'hAB, 4'd0);
        wait_acc(base + 3, "stall_pre");
        out_ready = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            cyc();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_hold", 32'(out_byte), 32'h34);
        end
        out_ready = 1'b1;
        drain("stall");

        // Back-to-back records: no idle cycle between packets.
        base = acc_cnt;
        expect_pkt({56'hA5_31_0000_00A0_55, 24'h0}, 7, 8'h61);
        expect_pkt({64'hA5_42_0000_0080_0000, 16'h0}, 8, 8'h67);
        send(4'h3, 32'hA0, 32'h55, 4'd1);
        send(4'h4, 32'h80, 32'h0, 4'd2);
        for (int unsigned i = 0; i < 20 && !out_valid; i++) cyc();
        gaps = 0;
        for (int unsigned i = 0; i < 100 && acc_cnt < base + exp_q.size() + (acc_cnt - base); i++) begin
            if (exp_q.size() == 0) break;
            if (!out_valid) gaps++;
            cyc();
        end
        check("b2b_gaps", gaps, 32'd0);
        drain("b2b");

        // Overflow: blocker packet stalled in SYNC, then DEPTH+3 strobes.
        out_ready = 1'b0;
        expect_pkt({48'hA5_00_0000_0001, 32'h0}, 6, 8'hA4);
        send(4'h0, 32'h1, 32'h0, 4'd0);
        repeat (3) cyc();
        for (int unsigned s = 0; s < DEPTH + 3; s++) begin
            if (s < DEPTH) expect_pkt({8'hA5, 8'h51, 8'h00, 8'h00, 8'h01, 8'(s), 8'(s), 24'h0}, 7, 8'hF5);
            send(4'h5, 32'h100 + s, s, 4'd1);
        end
        cyc();
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_drops", 32'(drop_count), 32'd3);
        out_ready = 1'b1;
        drain("ovf");
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_drops_sticky", 32'(drop_count), 32'd3);

        // Reset mid-DATA: packet abandoned, nothing emitted after release.
        base = acc_cnt;
        expect_pkt(80'hA5_04_0000_0000_AABB_CCDD, 10, 8'h00);
        send(4'h0, 32'h0, 32'hDDCCBBAA, 4'd4);
        wait_acc(base + 7, "rst_pre");
        #1 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_byte", 32'(out_byte), 32'h00);
        check("arst_overflow", 32'(overflow), 32'd0);
        check("arst_drop_count", 32'(drop_count), 32'd0);
        exp_q.delete();
        repeat (2) cyc();
        rst_n = 1'b1;
        gaps = 0;
        for (int unsigned i = 0; i < 20; i++) begin
            cyc();
            if (out_valid) gaps++;
        end
        check("post_rst_quiet", gaps, 32'd0);

        expect_pkt({56'hA5_01_0000_7FE5_6C, 24'h0}, 7, 8'h52);
        send(4'h0, 32'h7fe5, 32'h6c, 4'd1);
        drain("post_rst_pkt");
        check("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
